// File: rtl/vga_pkg.sv
// Shared types for the VGA capture path: geometry defaults, pixel word, capture FSM states.
package vga_pkg;

    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    // One captured pixel; rgb packed {B,G,R} with R in [7:0].
    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } pixel_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } capture_state_e;

    // Increment that sticks at the top of the 10-bit range.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_frame_capture_if.sv
// Captured pixel stream.
// Handshake: a beat transfers on a clk50 rising edge where pix_valid & pix_ready are both 1;
// while pix_valid is 1 and pix_ready is 0, pix_x/pix_y/pix_rgb hold their value; pix_valid
// never depends on pix_ready.
interface vga_frame_capture_if;

    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;

    modport master (output pix_valid, pix_x, pix_y, pix_rgb, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_rgb, output pix_ready);

endinterface

// File: rtl/vga_frame_capture_pixel_fifo.sv
// Small synchronous FIFO of pixel words; a push while full is dropped and reported.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk50,
    input  logic   reset,
    input  logic   push,
    input  pixel_t din,
    input  logic   pop,
    output pixel_t dout,
    output logic   full,
    output logic   empty,
    output logic   dropped
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pixel_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;
    // Head reads as zero when empty so the stream outputs are clean after reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; no reset needed, contents are qualified by count.
    always_ff @(posedge clk50) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_capture.sv
// VGA receiver/checker: recovers (x,y) from the sampled VGA bus, streams active pixels
// through a FIFO and flags line/frame geometry errors.
module vga_frame_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE   = V_ACTIVE_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk50,
    input  logic                reset,
    input  logic                vga_clk,
    input  logic                vga_hs,
    input  logic                vga_vs,
    input  logic                vga_blank_n,
    input  logic [7:0]          vga_r,
    input  logic [7:0]          vga_g,
    input  logic [7:0]          vga_b,
    input  logic                clr_status,
    vga_frame_capture_if.master pix,
    output logic                frame_start,
    output logic                locked,
    output logic                line_err,
    output logic                frame_err,
    output logic                overflow,
    output capture_state_e      capture_state
);

    logic           s1_clk, s1_hs, s1_vs, s1_blank_n;
    logic [23:0]    s1_rgb;
    logic           s2_clk, s2_hs, s2_vs;
    logic           pix_edge, hs_fall, vs_fall;

    capture_state_e state, state_next;
    logic [9:0]     col, row, col_next, row_next;
    logic           push, line_bad, frame_bad, fs_next;

    logic           wr_valid;
    pixel_t         wr_pix;
    pixel_t         head;
    logic           fifo_full, fifo_empty, fifo_dropped, pop;

    // Two register stages on the VGA bus: S1 is the sample, S2 the previous sample.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            s1_clk <= 1'b0; s1_hs <= 1'b0; s1_vs <= 1'b0; s1_blank_n <= 1'b0;
            s1_rgb <= '0;
            s2_clk <= 1'b0; s2_hs <= 1'b0; s2_vs <= 1'b0;
        end else begin
            s1_clk <= vga_clk; s1_hs <= vga_hs; s1_vs <= vga_vs; s1_blank_n <= vga_blank_n;
            s1_rgb <= {vga_b, vga_g, vga_r};
            s2_clk <= s1_clk; s2_hs <= s1_hs; s2_vs <= s1_vs;
        end
    end

    assign pix_edge = s1_clk & ~s2_clk;
    assign hs_fall  = ~s1_hs & s2_hs;
    assign vs_fall  = ~s1_vs & s2_vs;

    // Next state, counters and error strobes; line handling precedes the frame check so a
    // coincident hs/vs fall checks the already-advanced row.
    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        push       = 1'b0;
        line_bad   = 1'b0;
        frame_bad  = 1'b0;
        fs_next    = 1'b0;
        if (state == HUNT) begin
            if (vs_fall) begin
                state_next = LOCKED;
                fs_next    = 1'b1;
                col_next   = '0;
                row_next   = '0;
            end
        end else begin
            if (pix_edge && s1_blank_n) begin
                push     = 1'b1;
                col_next = sat_inc(col);
            end
            if (hs_fall) begin
                if (col_next != '0) begin
                    line_bad = (col_next != 10'(H_ACTIVE));
                    row_next = sat_inc(row);
                end
                col_next = '0;
            end
            if (vs_fall) begin
                fs_next   = 1'b1;
                frame_bad = (row_next != 10'(V_ACTIVE));
                row_next  = '0;
                col_next  = '0;
                if (frame_bad) state_next = HUNT;
            end
        end
    end

    // FSM state, position counters, frame_start pulse and sticky status flags.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            col         <= '0;
            row         <= '0;
            frame_start <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_next;
            col         <= col_next;
            row         <= row_next;
            frame_start <= fs_next;
            line_err    <= (line_err  & ~clr_status) | line_bad;
            frame_err   <= (frame_err & ~clr_status) | frame_bad;
            overflow    <= (overflow  & ~clr_status) | fifo_dropped;
        end
    end

    // Write staging: the pixel word is latched one cycle before it enters the FIFO.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            wr_valid <= 1'b0;
            wr_pix   <= '0;
        end else begin
            wr_valid <= push;
            wr_pix   <= {col, row, s1_rgb};
        end
    end

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk50   (clk50),
        .reset   (reset),
        .push    (wr_valid),
        .din     (wr_pix),
        .pop     (pop),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dropped (fifo_dropped)
    );

    assign pop           = pix.pix_valid & pix.pix_ready;
    assign pix.pix_valid = ~fifo_empty;
    assign pix.pix_x     = head.x;
    assign pix.pix_y     = head.y;
    assign pix.pix_rgb   = head.rgb;
    assign locked        = (state == LOCKED);
    assign capture_state = state;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a reduced 8x4 geometry.
module tb_vga_frame_capture;
    import vga_pkg::*;

    localparam int H = 8;
    localparam int V = 4;

    logic           clk50 = 1'b0;
    logic           reset = 1'b1;
    logic           vga_clk = 1'b0, vga_hs = 1'b1, vga_vs = 1'b1, vga_blank_n = 1'b0;
    logic [7:0]     vga_r = '0, vga_g = '0, vga_b = '0;
    logic           clr_status = 1'b0;
    logic           frame_start, locked, line_err, frame_err, overflow;
    capture_state_e capture_state;

    vga_frame_capture_if pix_if ();

    vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(4)) dut (
        .clk50         (clk50),
        .reset         (reset),
        .vga_clk       (vga_clk),
        .vga_hs        (vga_hs),
        .vga_vs        (vga_vs),
        .vga_blank_n   (vga_blank_n),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .clr_status    (clr_status),
        .pix           (pix_if),
        .frame_start   (frame_start),
        .locked        (locked),
        .line_err      (line_err),
        .frame_err     (frame_err),
        .overflow      (overflow),
        .capture_state (capture_state)
    );

    // clock
    always #10 clk50 = ~clk50;

    int          n_cmp = 0;
    int          n_err = 0;
    int          fs_count = 0;
    logic [43:0] exp_q[$];
    logic [43:0] last_pix = '0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // scoreboard: every accepted beat is compared against the head of exp_q
    always @(negedge clk50) begin
        if (!reset) begin
            if (frame_start) fs_count++;
            if (pix_if.pix_valid && pix_if.pix_ready) begin
                last_pix = {pix_if.pix_x, pix_if.pix_y, pix_if.pix_rgb};
                if (exp_q.size() == 0) check_eq("pix_extra", 64'(exp_q.size()), 64'd1);
                else check_eq("pix", 64'(last_pix), 64'(exp_q.pop_front()));
            end
        end
    end

    // one pixel period = two clk50 cycles, vga_clk rises in the second
    task automatic drive_pix(input logic blank_n, input logic hs, input logic vs,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        vga_blank_n = blank_n; vga_hs = hs; vga_vs = vs;
        vga_r = r; vga_g = g; vga_b = b;
        vga_clk = 1'b0;
        @(posedge clk50); #1;
        vga_clk = 1'b1;
        @(posedge clk50); #1;
    endtask

    task automatic drive_porch(input logic vs);
        repeat (2) drive_pix(1'b0, 1'b1, vs, 8'h00, 8'h00, 8'h00);
        repeat (2) drive_pix(1'b0, 1'b0, vs, 8'h00, 8'h00, 8'h00);
        repeat (2) drive_pix(1'b0, 1'b1, vs, 8'h00, 8'h00, 8'h00);
    endtask

    // active line y: rgb = {B=x, G=y, R=A5}; column drop_c is blanked; only the first keep
    // captured pixels are expected to survive
    task automatic drive_line(input int y, input bit cap, input int drop_c, input int keep);
        int cap_x = 0;
        for (int c = 0; c < H; c++) begin
            if (c == drop_c) begin
                drive_pix(1'b0, 1'b1, 1'b1, 8'hA5, 8'(y), 8'(c));
            end else begin
                if (cap && cap_x < keep) exp_q.push_back({10'(cap_x), 10'(y), 8'(c), 8'(y), 8'hA5});
                cap_x++;
                drive_pix(1'b1, 1'b1, 1'b1, 8'hA5, 8'(y), 8'(c));
            end
        end
        drive_porch(1'b1);
    endtask

    task automatic blank_line(input logic vs);
        repeat (H) drive_pix(1'b0, 1'b1, vs, 8'h00, 8'h00, 8'h00);
        drive_porch(vs);
    endtask

    // front porch line, two VS-low lines, back porch line
    task automatic vsync_block();
        blank_line(1'b1);
        blank_line(1'b0);
        blank_line(1'b0);
        blank_line(1'b1);
    endtask

    task automatic send_frame(input int n_lines, input bit cap, input int drop_y);
        for (int y = 0; y < n_lines; y++) drive_line(y, cap, (y == drop_y) ? 2 : -1, H);
        vsync_block();
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        @(posedge clk50); #1;
        clr_status = 1'b0;
        @(negedge clk50);
    endtask

    initial begin
        pix_if.pix_ready = 1'b1;
        repeat (3) @(posedge clk50);
        #1 reset = 1'b0;
        @(negedge clk50);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_state", capture_state, HUNT);
        check_eq("rst_valid", pix_if.pix_valid, 0);
        check_eq("rst_flags", {line_err, frame_err, overflow, frame_start}, 0);
        check_eq("rst_head", {pix_if.pix_x, pix_if.pix_y, pix_if.pix_rgb}, 0);

        // lock, then one clean frame
        @(posedge clk50); #1;
        vsync_block();
        check_eq("lock_locked", locked, 1);
        check_eq("lock_fs", fs_count, 1);
        send_frame(V, 1'b1, -1);
        check_eq("clean_flags", {line_err, frame_err, overflow}, 0);
        check_eq("clean_locked", locked, 1);
        check_eq("clean_last", last_pix, {10'd7, 10'd3, 8'd7, 8'd3, 8'hA5});
        check_eq("clean_fs", fs_count, 2);

        // reset mid-frame, hunt until next VS fall, frame restarts at row 0
        drive_line(0, 1'b1, -1, H);
        drive_line(1, 1'b1, -1, H);
        check_eq("pre_rst_drained", exp_q.size(), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk50);
        #1 reset = 1'b0;
        @(negedge clk50);
        check_eq("midrst_locked", locked, 0);
        check_eq("midrst_valid", pix_if.pix_valid, 0);
        @(posedge clk50); #1;
        drive_line(2, 1'b0, -1, H);
        drive_line(3, 1'b0, -1, H);
        check_eq("hunt_locked", locked, 0);
        vsync_block();
        check_eq("relock_locked", locked, 1);
        send_frame(V, 1'b1, -1);

        // one blanked pixel on line 1
        send_frame(V, 1'b1, 1);
        check_eq("drop_line_err", line_err, 1);
        check_eq("drop_locked", locked, 1);
        check_eq("drop_frame_err", frame_err, 0);
        pulse_clr();
        check_eq("drop_clr", line_err, 0);

        // short frame: frame error, hunt, relock one frame later
        send_frame(V - 1, 1'b1, -1);
        check_eq("short_frame_err", frame_err, 1);
        check_eq("short_locked", locked, 0);
        send_frame(V, 1'b0, -1);
        check_eq("short_relock", locked, 1);
        check_eq("short_sticky", frame_err, 1);
        pulse_clr();
        check_eq("short_clr", frame_err, 0);

        // consumer stall for a whole line: 4 held, rest dropped
        pix_if.pix_ready = 1'b0;
        drive_line(0, 1'b1, -1, 4);
        @(negedge clk50);
        check_eq("ovf_valid", pix_if.pix_valid, 1);
        check_eq("ovf_head", {pix_if.pix_x, pix_if.pix_y}, {10'd0, 10'd0});
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_locked", locked, 1);
        @(posedge clk50); #1;
        pix_if.pix_ready = 1'b1;
        for (int y = 1; y < V; y++) drive_line(y, 1'b1, -1, H);
        vsync_block();
        check_eq("ovf_sticky", overflow, 1);
        check_eq("ovf_line_err", line_err, 0);
        check_eq("ovf_fs", fs_count, 8);
        pulse_clr();
        check_eq("ovf_clr", overflow, 0);

        // latency of one isolated pixel into an empty FIFO
        @(posedge clk50); #1;
        vga_clk = 1'b0; vga_blank_n = 1'b0;
        @(posedge clk50); #1;
        exp_q.push_back({10'd0, 10'd0, 8'h3C, 8'h00, 8'h5A});
        vga_r = 8'h5A; vga_g = 8'h00; vga_b = 8'h3C;
        vga_blank_n = 1'b1; vga_clk = 1'b1;
        @(posedge clk50); @(negedge clk50);
        check_eq("lat_k", pix_if.pix_valid, 0);
        @(posedge clk50); @(negedge clk50);
        check_eq("lat_k1", pix_if.pix_valid, 0);
        @(posedge clk50); @(negedge clk50);
        check_eq("lat_k2", pix_if.pix_valid, 1);
        @(posedge clk50); #1;
        vga_blank_n = 1'b0;
        repeat (20) @(posedge clk50);
        @(negedge clk50);
        check_eq("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
